mac_column_sequencer: RTL and testbench

//  Sequences one MAC column over a convolution window. For each output pixel it issues KW column reads
//  to the image and weight buffers, accumulates the column partial sums, and returns one result per pixel.

---
 rtl/mac_column_sequencer_pkg.sv | 46 ++++
 rtl/mac_column_sequencer_if.sv | 50 +++++
 rtl/mac_psum_accumulator.sv | 66 ++++++
 rtl/mac_column_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mac_column_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_column_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_pkg
//  Description : Shared definitions for the MAC column sequencer.
//                - default parameter values (operand, column, address and
//                  counter widths, kernel size limit)
//                - accumulator sizing rule
//                - sequencer state encoding (IDLE/READ/DRAIN/OUT/FIN)
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    localparam int DATA_WIDTH_DEF       = 8;
    localparam int COLUMN_NUM_DEF       = 6;
    // Product of two DATA_WIDTH operands summed over COLUMN_NUM MACs.
    localparam int COLUMN_OUT_WIDTH_DEF = 2 * DATA_WIDTH_DEF + $clog2(COLUMN_NUM_DEF);
    localparam int KW_MAX_DEF           = 8;
    localparam int ADDR_WIDTH_DEF       = 8;
    localparam int CNT_WIDTH_DEF        = 10;
    localparam int ACC_GUARD_BITS       = 2;

    // The accumulator must hold KW_MAX column sums without overflow; a couple
    // of guard bits are added on top of the strict minimum.
    function automatic int acc_width_rule(input int col_out_width, input int kw_max);
        return col_out_width + $clog2(kw_max) + ACC_GUARD_BITS;
    endfunction

    localparam int ACC_WIDTH_DEF = acc_width_rule(COLUMN_OUT_WIDTH_DEF, KW_MAX_DEF);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN,
        OUT   = ST_OUT,
        FIN   = ST_FIN
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_column_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_column_sequencer_if
//  Description : Bus bundle between the layer controller / buffers / MAC
//                column (master side) and the column sequencer (slave side).
//  Signals     : start, kw, num_out, base_addr   - job configuration
//                rd_en, img_addr, wgt_addr        - buffer read port
//                psum_column                      - column sum, 1 cycle after rd_en
//                result, result_valid, result_ready - result handshake
//                busy, done                       - job status
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_column_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int COLUMN_OUT_WIDTH = COLUMN_OUT_WIDTH_DEF,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF,
    parameter int KW_MAX           = KW_MAX_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH        = CNT_WIDTH_DEF
);

    localparam int KW_W = $clog2(KW_MAX) + 1;

    logic                        start;
    logic [KW_W-1:0]             kw;
    logic [CNT_WIDTH-1:0]        num_out;
    logic [ADDR_WIDTH-1:0]       base_addr;
    logic                        rd_en;
    logic [ADDR_WIDTH-1:0]       img_addr;
    logic [ADDR_WIDTH-1:0]       wgt_addr;
    logic [COLUMN_OUT_WIDTH-1:0] psum_column;
    logic [ACC_WIDTH-1:0]        result;
    logic                        result_valid;
    logic                        result_ready;
    logic                        busy;
    logic                        done;

    modport master (
        output start, kw, num_out, base_addr, psum_column, result_ready,
        input  rd_en, img_addr, wgt_addr, result, result_valid, busy, done
    );

    modport slave (
        input  start, kw, num_out, base_addr, psum_column, result_ready,
        output rd_en, img_addr, wgt_addr, result, result_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/mac_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mac_psum_accumulator
//  Description : Accumulates signed column partial sums over one window.
//                The first sum of a window overwrites the accumulator; later
//                ones add to it (two's-complement wrap). On load_out the
//                final window value (including the sum arriving that cycle)
//                is captured into the result register.
//                Build option MAC_SEQ_RELU_EN: negative results are clamped
//                to zero at the result register.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                acc_en     - psum is valid this cycle
//                first      - psum belongs to column 0 of the window
//                load_out   - capture window result
//                psum       - signed column sum
//                result     - registered window result
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_psum_accumulator
    import mac_seq_pkg::*;
#(
    parameter int COLUMN_OUT_WIDTH = COLUMN_OUT_WIDTH_DEF,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        acc_en,
    input  wire logic                        first,
    input  wire logic                        load_out,
    input  wire logic [COLUMN_OUT_WIDTH-1:0] psum,
    output logic      [ACC_WIDTH-1:0]        result
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_result;
    logic [ACC_WIDTH-1:0] w_psum_ext;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [ACC_WIDTH-1:0] w_out;

    assign w_psum_ext = {{(ACC_WIDTH - COLUMN_OUT_WIDTH){psum[COLUMN_OUT_WIDTH-1]}}, psum};
    assign w_acc_next = (first ? '0 : r_acc) + w_psum_ext;

`ifdef MAC_SEQ_RELU_EN
    assign w_out = w_acc_next[ACC_WIDTH-1] ? '0 : w_acc_next;
`else
    assign w_out = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (acc_en) begin
                r_acc <= w_acc_next;
            end
            if (load_out) begin
                r_result <= w_out;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/mac_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_column_sequencer
//  Description : Sequences one MAC column over a convolution window. For each
//                output pixel it issues kw reads (image address base+pix+col,
//                weight address col), accumulates the returned column sums
//                and offers one result per pixel on a valid/ready handshake.
//                Build option MAC_SEQ_RELU_EN (in mac_psum_accumulator)
//                applies ReLU to each result; timing is unchanged.
//  Ports       : i_clk  - clock
//                i_rst  - synchronous active-high reset (aborts without done)
//                bus    - mac_column_sequencer_if.slave (config, buffer reads,
//                         column sums, result handshake, busy/done)
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_column_sequencer
    import mac_seq_pkg::*;
#(
    parameter int COLUMN_OUT_WIDTH = COLUMN_OUT_WIDTH_DEF,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF,
    parameter int KW_MAX           = KW_MAX_DEF,
    parameter int ADDR_WIDTH       = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
    input wire logic               i_clk,
    input wire logic               i_rst,
    mac_column_sequencer_if.slave  bus
);

    localparam int KW_W = $clog2(KW_MAX) + 1;

    seq_state_e            r_state;
    logic [KW_W-1:0]       r_kw;
    logic [KW_W-1:0]       r_col;
    logic [CNT_WIDTH-1:0]  r_num_out;
    logic [CNT_WIDTH-1:0]  r_pix;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_img_addr;
    logic [ADDR_WIDTH-1:0] r_wgt_addr;
    logic                  r_result_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_acc_en;
    logic                  r_acc_first;
    logic                  w_load_out;
    logic [ACC_WIDTH-1:0]  w_result;

    // Image address wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] f_img_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [CNT_WIDTH-1:0]  pix,
        input logic [KW_W-1:0]       col
    );
        return base + ADDR_WIDTH'(pix) + ADDR_WIDTH'(col);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_kw           <= '0;
            r_col          <= '0;
            r_num_out      <= '0;
            r_pix          <= '0;
            r_base         <= '0;
            r_rd_en        <= 1'b0;
            r_img_addr     <= '0;
            r_wgt_addr     <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_acc_en       <= 1'b0;
            r_acc_first    <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            // Column sums return one cycle after each read.
            r_acc_en    <= r_rd_en;
            r_acc_first <= r_rd_en && (r_col == '0);

            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_kw      <= (bus.kw == '0) ? KW_W'(1) : bus.kw;
                        r_num_out <= bus.num_out;
                        r_base    <= bus.base_addr;
                        r_pix     <= '0;
                        r_col     <= '0;
                        r_busy    <= 1'b1;
                        if (bus.num_out == '0) begin
                            r_state <= FIN;
                        end else begin
                            // First read is issued in the first READ cycle.
                            r_state    <= READ;
                            r_rd_en    <= 1'b1;
                            r_img_addr <= bus.base_addr;
                            r_wgt_addr <= '0;
                        end
                    end
                end

                READ: begin
                    if (r_col == r_kw - KW_W'(1)) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_col      <= r_col + KW_W'(1);
                        r_img_addr <= f_img_addr(r_base, r_pix, r_col + KW_W'(1));
                        r_wgt_addr <= ADDR_WIDTH'(r_col + KW_W'(1));
                    end
                end

                DRAIN: begin
                    r_result_valid <= 1'b1;
                    r_state        <= OUT;
                end

                OUT: begin
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        if (r_pix == r_num_out - CNT_WIDTH'(1)) begin
                            r_state <= FIN;
                        end else begin
                            r_pix      <= r_pix + CNT_WIDTH'(1);
                            r_col      <= '0;
                            r_rd_en    <= 1'b1;
                            r_img_addr <= f_img_addr(r_base, r_pix + CNT_WIDTH'(1), '0);
                            r_wgt_addr <= '0;
                            r_state    <= READ;
                        end
                    end
                end

                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The DRAIN cycle carries the last column sum; the result register
    // captures the completed window in the same edge that enters OUT.
    assign w_load_out = (r_state == DRAIN);

    mac_psum_accumulator #(
        .COLUMN_OUT_WIDTH (COLUMN_OUT_WIDTH),
        .ACC_WIDTH        (ACC_WIDTH)
    ) u_acc (
        .clk      (i_clk),
        .rst      (i_rst),
        .acc_en   (r_acc_en),
        .first    (r_acc_first),
        .load_out (w_load_out),
        .psum     (bus.psum_column),
        .result   (w_result)
    );

    assign bus.rd_en        = r_rd_en;
    assign bus.img_addr     = r_img_addr;
    assign bus.wgt_addr     = r_wgt_addr;
    assign bus.result       = w_result;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_column_sequencer
//  Description : Self-checking bench for mac_column_sequencer. A table of
//                jobs (config, column-sum pattern, ready back-pressure and
//                hand-computed result) is run in a loop, followed by hand
//                written reset-abort and restart sequences. Honours
//                MAC_SEQ_RELU_EN when deciding expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_column_sequencer;
    import mac_seq_pkg::*;

    localparam int AW  = ADDR_WIDTH_DEF;
    localparam int COW = COLUMN_OUT_WIDTH_DEF;
`ifdef MAC_SEQ_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        int kw;
        int num_out;
        int base;
        int psum_a;       // column sum for col c = psum_a + c*psum_step
        int psum_step;
        int ready_delay;  // cycles ready is held low once valid appears
        int exp_raw;      // hand-computed window sum (before optional ReLU)
        bit poke;         // pulse start again while busy
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_column_sequencer_if bus ();

    mac_column_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int mon_base = 0, mon_kw = 1, mon_pix = 0, mon_col = 0, rd_count = 0;
    int psum_a = 0, psum_step = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic arm_monitor(input int base, input int kw_eff);
        mon_base = base;
        mon_kw   = kw_eff;
        mon_pix  = 0;
        mon_col  = 0;
        rd_count = 0;
    endtask

    // Buffer model: checks each read address and returns the column sum
    // one cycle after the read; junk is driven on cycles with no read.
    initial begin : responder
        logic p_en;
        int   p_col;
        forever begin
            @(negedge clk);
            p_en  = (bus.rd_en === 1'b1);
            p_col = int'(bus.wgt_addr);
            if (p_en) begin
                check("img_addr", longint'(bus.img_addr), longint'((mon_base + mon_pix + mon_col) % (1 << AW)));
                check("wgt_addr", longint'(bus.wgt_addr), longint'(mon_col));
                rd_count++;
                mon_col++;
                if (mon_col >= mon_kw) begin
                    mon_col = 0;
                    mon_pix++;
                end
            end
            @(posedge clk);
            #1;
            bus.psum_column = p_en ? COW'(psum_a + p_col * psum_step) : COW'(777);
        end
    end

    task automatic run_job(input vec_t v, input int idx);
        int kw_eff, results, cyc, wait_cnt, done_cyc;
        bit finished, xfer_prev;
        longint captured, exp_r;
        kw_eff   = (v.kw == 0) ? 1 : v.kw;
        exp_r    = (RELU && v.exp_raw < 0) ? 0 : v.exp_raw;
        arm_monitor(v.base, kw_eff);
        psum_a    = v.psum_a;
        psum_step = v.psum_step;
        results = 0; cyc = 0; wait_cnt = 0; done_cyc = -1;
        finished = 1'b0; xfer_prev = 1'b0; captured = 0;

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.kw        = 4'(v.kw);
        bus.num_out   = 10'(v.num_out);
        bus.base_addr = 8'(v.base);
        @(posedge clk); #1;
        // Config changes after start must not matter.
        bus.start     = 1'b0;
        bus.kw        = 4'd1;
        bus.num_out   = 10'd1;
        bus.base_addr = 8'hee;

        while (!finished && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.result_ready = 1'b0;
            if (v.poke && cyc == 3) begin
                bus.start     = 1'b1;
                bus.kw        = 4'd7;
                bus.num_out   = 10'd9;
                bus.base_addr = 8'd99;
            end
            if (v.poke && cyc == 4) bus.start = 1'b0;
            if (cyc == 1) check($sformatf("v%0d_busy", idx), longint'(bus.busy), 1);
            if (xfer_prev) begin
                if (results < v.num_out)
                    check($sformatf("v%0d_reads_resume", idx), longint'(bus.rd_en), 1);
                xfer_prev = 1'b0;
            end
            if (bus.done === 1'b1) begin
                finished = 1'b1;
                done_cyc = cyc;
            end
            if (bus.result_valid === 1'b1) begin
                check($sformatf("v%0d_no_rd_in_out", idx), longint'(bus.rd_en), 0);
                if (wait_cnt == 0) begin
                    captured = longint'($signed(bus.result));
                    check($sformatf("v%0d_result", idx), captured, exp_r);
                end else begin
                    check($sformatf("v%0d_stable", idx), longint'($signed(bus.result)), captured);
                end
                if (wait_cnt == v.ready_delay) begin
                    bus.result_ready = 1'b1;
                    results++;
                    xfer_prev = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
        if (!finished) check($sformatf("v%0d_done_timeout", idx), 0, 1);
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.num_out * (kw_eff + 2 + v.ready_delay) + 2);
        check($sformatf("v%0d_results", idx), results, v.num_out);
        check($sformatf("v%0d_reads", idx), rd_count, v.num_out * kw_eff);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), longint'(bus.done), 0);
        check($sformatf("v%0d_idle_busy", idx), longint'(bus.busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},    longint'(bus.rd_en), 0);
        check({tag, "_img_addr"}, longint'(bus.img_addr), 0);
        check({tag, "_wgt_addr"}, longint'(bus.wgt_addr), 0);
        check({tag, "_result"},   longint'(bus.result), 0);
        check({tag, "_valid"},    longint'(bus.result_valid), 0);
        check({tag, "_busy"},     longint'(bus.busy), 0);
        check({tag, "_done"},     longint'(bus.done), 0);
    endtask

    initial begin : main
        vec_t vecs[7];
        bit   seen;
        int   noise;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.kw           = '0;
        bus.num_out      = '0;
        bus.base_addr    = '0;
        bus.psum_column  = '0;
        bus.result_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        //           kw num base   a    step dly  exp   poke
        vecs[0] = '{ 3, 2,  10,    5,   0,   0,   15,   1'b0 };
        vecs[1] = '{ 0, 1,  3,     42,  0,   0,   42,   1'b0 };
        vecs[2] = '{ 2, 0,  0,     9,   0,   0,   0,    1'b0 };
        vecs[3] = '{ 2, 3,  0,    -100, 50,  5,  -150,  1'b0 };
        vecs[4] = '{ 8, 2,  250,   1,   1,   1,   36,   1'b0 };
        vecs[5] = '{ 1, 1,  255,  -7,   0,   0,  -7,    1'b0 };
        vecs[6] = '{ 5, 4,  100,  -3,   2,   2,   5,    1'b1 };

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], i);
        end

        // Reset in the middle of READ aborts without done.
        arm_monitor(20, 4);
        psum_a = 1; psum_step = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.kw = 4'd4; bus.num_out = 10'd3; bus.base_addr = 8'd20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.rd_en === 1'b1) seen = 1'b1;
        end
        check("abort_reads_began", longint'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        noise = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0) noise++;
        end
        check("abort_quiet", noise, 0);

        // Clean restart after the abort.
        run_job(vecs[0], 10);
        run_job(vecs[3], 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
